// File: rtl/decode_unit.sv
// Decode stage: register file, immediate extension, branch compare, next-PC
// select, D/E pipeline register and a per-register pending-write scoreboard.
// Optional macro DECODE_WT_BYPASS_EN enables write-through reads and lets a
// draining scoreboard entry report not-busy in the cycle it retires.
module decode_unit #(
  parameter int unsigned DW   = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] pc_d,
  input  logic [31:0]   instr_d,
  input  logic          valid_d,
  input  logic          wr_en_d,
  input  logic [AW-1:0] a3_d,
  input  logic [1:0]    ext_op,
  input  logic [2:0]    cmp_op,
  input  logic [1:0]    br,
  input  logic [DW-1:0] fwd_rs,
  input  logic [DW-1:0] fwd_rt,
  input  logic          jr,
  input  logic [DW-1:0] epc,
  input  logic          we_w,
  input  logic [AW-1:0] a3_w,
  input  logic [DW-1:0] wd_w,
  input  logic          stall_d,
  input  logic          flush_e,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  output logic          cmp_out,
  output logic [DW-1:0] npc,
  output logic [DW-1:0] pc_e,
  output logic [31:0]   instr_e,
  output logic [DW-1:0] rd1_e,
  output logic [DW-1:0] rd2_e,
  output logic [DW-1:0] ext_e,
  output logic          valid_e,
  output logic          wr_en_e,
  output logic [AW-1:0] a3_e,
  output logic          busy_rs,
  output logic          busy_rt
);

  // Extension is computed at least 32 bits wide so the shifted-by-16 form fits.
  localparam int unsigned XW = (DW > 32) ? DW : 32;

  logic [15:0]    imm;
  logic [AW-1:0]  rs_a;
  logic [AW-1:0]  rt_a;
  logic [XW-1:0]  sext_wide;
  logic [XW-1:0]  ext_wide;
  logic [DW-1:0]  ext;
  logic [DW-1:0]  pc4;
  logic [DW-1:0]  br_off;
  logic [DW-1:0]  jt_abs;
  logic           wr;
  logic           issue;
  logic [DW-1:0]  regs [NREG];
  logic [1:0]     cnt  [NREG];

  assign imm       = instr_d[15:0];
  assign rs_a      = AW'(instr_d[25:21]);
  assign rt_a      = AW'(instr_d[20:16]);
  assign sext_wide = {{(XW-16){imm[15]}}, imm};
  assign wr        = we_w && (a3_w != '0);
  assign issue     = valid_d && wr_en_d && (a3_d != '0) && !stall_d && !flush_e;

  // Immediate extension select
  always_comb begin
    ext_wide = XW'(imm);
    case (ext_op)
      2'b01:   ext_wide = sext_wide;
      2'b10:   ext_wide = XW'({imm, 16'h0000});
      default: ext_wide = XW'(imm);
    endcase
  end

  assign ext = ext_wide[DW-1:0];

  // Signed compare on the forwarded operands (sign bit + zero test)
  always_comb begin
    cmp_out = 1'b0;
    case (cmp_op)
      3'b000:  cmp_out = (fwd_rs == fwd_rt);
      3'b001:  cmp_out = (fwd_rs != fwd_rt);
      3'b010:  cmp_out = fwd_rs[DW-1] || (fwd_rs == '0);
      3'b011:  cmp_out = !fwd_rs[DW-1] && (fwd_rs != '0);
      3'b100:  cmp_out = fwd_rs[DW-1];
      3'b101:  cmp_out = !fwd_rs[DW-1];
      default: cmp_out = 1'b0;
    endcase
  end

  assign pc4    = pc_d + DW'(4);
  assign br_off = sext_wide[DW-1:0] << 2;

  // Absolute jump target keeps the PC region bits above the 28-bit field
  if (DW > 28) begin : g_jt_wide
    assign jt_abs = {pc_d[DW-1:28], instr_d[25:0], 2'b00};
  end else begin : g_jt_narrow
    logic [27:0] jt28;
    assign jt28   = {instr_d[25:0], 2'b00};
    assign jt_abs = jt28[DW-1:0];
  end

  // Next-PC select
  always_comb begin
    npc = pc4;
    case (br)
      2'b01:   npc = cmp_out ? (pc4 + br_off) : pc4;
      2'b10:   npc = jr ? fwd_rs : jt_abs;
      2'b11:   npc = epc;
      default: npc = pc4;
    endcase
  end

  // Register file reads; r0 is hardwired to zero
`ifdef DECODE_WT_BYPASS_EN
  assign rd1 = (rs_a == '0) ? '0 : ((wr && (a3_w == rs_a)) ? wd_w : regs[rs_a]);
  assign rd2 = (rt_a == '0) ? '0 : ((wr && (a3_w == rt_a)) ? wd_w : regs[rt_a]);
`else
  assign rd1 = (rs_a == '0) ? '0 : regs[rs_a];
  assign rd2 = (rt_a == '0) ? '0 : regs[rt_a];
`endif

  // Register file write port, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr) begin
      regs[a3_w] <= wd_w;
    end
  end

  // Pending-write counters: +1 on issue, -1 on W write, saturating 0..3
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) cnt[i] <= 2'd0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (issue && (a3_d == AW'(i)) && !(we_w && (a3_w == AW'(i)))) begin
          if (cnt[i] != 2'd3) cnt[i] <= cnt[i] + 2'd1;
        end else if (we_w && (a3_w == AW'(i)) && !(issue && (a3_d == AW'(i)))) begin
          if (cnt[i] != 2'd0) cnt[i] <= cnt[i] - 2'd1;
        end
      end
    end
  end

  // Busy flags; with bypass, the last outstanding write retiring now clears busy
`ifdef DECODE_WT_BYPASS_EN
  logic rs_drain;
  logic rt_drain;
  assign rs_drain = we_w && (a3_w == rs_a) && !(issue && (a3_d == rs_a)) && (cnt[rs_a] == 2'd1);
  assign rt_drain = we_w && (a3_w == rt_a) && !(issue && (a3_d == rt_a)) && (cnt[rt_a] == 2'd1);
  assign busy_rs  = (rs_a != '0) && (cnt[rs_a] != 2'd0) && !rs_drain;
  assign busy_rt  = (rt_a != '0) && (cnt[rt_a] != 2'd0) && !rt_drain;
`else
  assign busy_rs  = (rs_a != '0) && (cnt[rs_a] != 2'd0);
  assign busy_rt  = (rt_a != '0) && (cnt[rt_a] != 2'd0);
`endif

  // D/E pipeline register: reset, then flush, then stall, else load
  always_ff @(posedge clk) begin
    if (reset || flush_e) begin
      pc_e    <= '0;
      instr_e <= '0;
      rd1_e   <= '0;
      rd2_e   <= '0;
      ext_e   <= '0;
      valid_e <= 1'b0;
      wr_en_e <= 1'b0;
      a3_e    <= '0;
    end else if (!stall_d) begin
      pc_e    <= pc_d;
      instr_e <= instr_d;
      rd1_e   <= rd1;
      rd2_e   <= rd2;
      ext_e   <= ext;
      valid_e <= valid_d;
      wr_en_e <= wr_en_d;
      a3_e    <= a3_d;
    end
  end

endmodule

// File: tb/tb_decode_unit.sv
// Self-checking bench for decode_unit with a behavioural reference model.
module tb_decode_unit;
  localparam int unsigned DW = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, valid_d, wr_en_d, jr, we_w, stall_d, flush_e;
  logic [31:0] pc_d, instr_d, fwd_rs, fwd_rt, epc, wd_w;
  logic [4:0] a3_d, a3_w;
  logic [1:0] ext_op, br;
  logic [2:0] cmp_op;
  logic [31:0] rd1, rd2, npc, pc_e, instr_e, rd1_e, rd2_e, ext_e;
  logic cmp_out, valid_e, wr_en_e, busy_rs, busy_rt;
  logic [4:0] a3_e;

  decode_unit #(.DW(DW), .NREG(NREG), .AW(AW)) dut (
    .clk(clk), .reset(reset), .pc_d(pc_d), .instr_d(instr_d), .valid_d(valid_d),
    .wr_en_d(wr_en_d), .a3_d(a3_d), .ext_op(ext_op), .cmp_op(cmp_op), .br(br),
    .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .jr(jr), .epc(epc), .we_w(we_w), .a3_w(a3_w),
    .wd_w(wd_w), .stall_d(stall_d), .flush_e(flush_e), .rd1(rd1), .rd2(rd2),
    .cmp_out(cmp_out), .npc(npc), .pc_e(pc_e), .instr_e(instr_e), .rd1_e(rd1_e),
    .rd2_e(rd2_e), .ext_e(ext_e), .valid_e(valid_e), .wr_en_e(wr_en_e), .a3_e(a3_e),
    .busy_rs(busy_rs), .busy_rt(busy_rt)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] mregs [32];
  int          mpend [32];
  logic [31:0] e_pc, e_instr, e_rd1, e_rd2, e_ext;
  logic        e_valid, e_wr;
  logic [4:0]  e_a3;

  function automatic logic m_issue();
    return valid_d && wr_en_d && (a3_d != 0) && !stall_d && !flush_e;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'd0;
`ifdef DECODE_WT_BYPASS_EN
    if (we_w && a3_w == a) return wd_w;
`endif
    return mregs[a];
  endfunction

  function automatic logic m_busy(input logic [4:0] a);
    if (a == 0) return 1'b0;
`ifdef DECODE_WT_BYPASS_EN
    if (mpend[a] == 1 && we_w && a3_w == a && !(m_issue() && a3_d == a)) return 1'b0;
`endif
    return mpend[a] != 0;
  endfunction

  function automatic logic [31:0] m_ext(input logic [15:0] imm, input logic [1:0] op);
    int v;
    v = int'(imm);
    case (op)
      2'd1: begin
        if (imm >= 16'h8000) v = v - 65536;
        return 32'(v);
      end
      2'd2: return 32'(imm) * 32'd65536;
      default: return 32'(imm);
    endcase
  endfunction

  function automatic logic m_cmp(input logic [2:0] op, input logic [31:0] au, input logic [31:0] bu);
    int a, b;
    a = $signed(au);
    b = $signed(bu);
    case (op)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd2: return a <= 0;
      3'd3: return a > 0;
      3'd4: return a < 0;
      3'd5: return a >= 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_npc();
    logic [31:0] pc4;
    int s;
    pc4 = pc_d + 32'd4;
    s = int'(instr_d[15:0]);
    if (instr_d[15]) s = s - 65536;
    case (br)
      2'd0: return pc4;
      2'd1: return m_cmp(cmp_op, fwd_rs, fwd_rt) ? pc4 + 32'(s * 4) : pc4;
      2'd2: return jr ? fwd_rs : ((pc_d & 32'hF000_0000) | (32'(instr_d[25:0]) * 32'd4));
      default: return epc;
    endcase
  endfunction

  // Advance the model by one edge using the current inputs, then clock the DUT.
  task automatic tick();
    logic [31:0] r1, r2;
    logic iss;
    r1 = m_read(instr_d[25:21]);
    r2 = m_read(instr_d[20:16]);
    iss = m_issue();
    if (reset) begin
      for (int r = 0; r < 32; r++) begin mregs[r] = 0; mpend[r] = 0; end
      e_pc = 0; e_instr = 0; e_rd1 = 0; e_rd2 = 0; e_ext = 0; e_valid = 0; e_wr = 0; e_a3 = 0;
    end else begin
      if (flush_e) begin
        e_pc = 0; e_instr = 0; e_rd1 = 0; e_rd2 = 0; e_ext = 0; e_valid = 0; e_wr = 0; e_a3 = 0;
      end else if (!stall_d) begin
        e_pc = pc_d; e_instr = instr_d; e_rd1 = r1; e_rd2 = r2;
        e_ext = m_ext(instr_d[15:0], ext_op); e_valid = valid_d; e_wr = wr_en_d; e_a3 = a3_d;
      end
      for (int r = 1; r < 32; r++) begin
        if (iss && a3_d == r && !(we_w && a3_w == r)) begin
          if (mpend[r] < 3) mpend[r] = mpend[r] + 1;
        end else if (we_w && a3_w == r && !(iss && a3_d == r)) begin
          if (mpend[r] > 0) mpend[r] = mpend[r] - 1;
        end
      end
      if (we_w && a3_w != 0) mregs[a3_w] = wd_w;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 0; pc_d = 0; instr_d = 0; valid_d = 0; wr_en_d = 0; a3_d = 0; ext_op = 0;
    cmp_op = 0; br = 0; fwd_rs = 0; fwd_rt = 0; jr = 0; epc = 0; we_w = 0; a3_w = 0;
    wd_w = 0; stall_d = 0; flush_e = 0;
  endtask

  task automatic test_reset();
    reset = 1; stall_d = 1; valid_d = 1; wr_en_d = 1; a3_d = 5'd3; instr_d = $urandom;
    pc_d = $urandom; we_w = 1; a3_w = 5'd4; wd_w = $urandom;
    tick(); tick();
    checks++;
    if (pc_e !== 0 || instr_e !== 0 || rd1_e !== 0 || rd2_e !== 0 || ext_e !== 0 ||
        valid_e !== 0 || wr_en_e !== 0 || a3_e !== 0) begin
      failures++;
      $display("FAIL reset_e: pc_e=%h instr_e=%h valid_e=%b a3_e=%0d, required all 0", pc_e, instr_e, valid_e, a3_e);
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      instr_d = $urandom;
      #1;
      checks++;
      if (rd1 !== 0 || rd2 !== 0 || busy_rs !== 0 || busy_rt !== 0) begin
        failures++;
        $display("FAIL reset_rf: rd1=%h rd2=%h busy=%b%b, required 0", rd1, rd2, busy_rs, busy_rt);
      end
    end
  endtask

  task automatic test_regfile();
    idle();
    we_w = 1; a3_w = 5'd5; wd_w = 32'hDEADBEEF;
    tick();
    we_w = 0; instr_d = 32'd5 << 21; #1;
    checks++;
    if (rd1 !== 32'hDEADBEEF) begin
      failures++; $display("FAIL rf_r5: rd1=%h required deadbeef", rd1);
    end
    we_w = 1; a3_w = 5'd0; wd_w = 32'hFFFF_FFFF;
    tick();
    we_w = 0; instr_d = 32'd0; #1;
    checks++;
    if (rd1 !== 32'd0 || rd2 !== 32'd0) begin
      failures++; $display("FAIL rf_r0: rd1=%h rd2=%h required 0", rd1, rd2);
    end
    for (int k = 0; k < 30; k++) begin
      we_w = 1'($urandom); a3_w = 5'($urandom); wd_w = $urandom; instr_d = $urandom;
      #1;
      checks++;
      if (rd1 !== m_read(instr_d[25:21]) || rd2 !== m_read(instr_d[20:16])) begin
        failures++;
        $display("FAIL rf_rand: rd1=%h rd2=%h required %h %h", rd1, rd2,
                 m_read(instr_d[25:21]), m_read(instr_d[20:16]));
      end
      tick();
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] exp;
    idle();
    we_w = 1; a3_w = 5'd7; wd_w = 32'h1111_1111;
    tick();
    a3_w = 5'd7; wd_w = 32'h1234_5678; instr_d = 32'd7 << 21;
    #1;
`ifdef DECODE_WT_BYPASS_EN
    exp = 32'h1234_5678;
`else
    exp = 32'h1111_1111;
`endif
    checks++;
    if (rd1 !== exp) begin
      failures++; $display("FAIL same_cycle: rd1=%h required %h", rd1, exp);
    end
    tick();
    we_w = 0; #1;
    checks++;
    if (rd1 !== 32'h1234_5678) begin
      failures++; $display("FAIL after_write: rd1=%h required 12345678", rd1);
    end
  endtask

  task automatic test_ext();
    idle();
    for (int k = 0; k < 16; k++) begin
      instr_d = $urandom;
      if (k < 4) begin instr_d[15:0] = 16'h8001; ext_op = 2'(k); end
      else ext_op = 2'($urandom);
      tick();
      checks++;
      if (ext_e !== m_ext(instr_e[15:0], ext_op)) begin
        failures++;
        $display("FAIL ext op=%0d imm=%h: ext_e=%h required %h", ext_op, instr_e[15:0], ext_e,
                 m_ext(instr_e[15:0], ext_op));
      end
    end
  endtask

  task automatic test_branch();
    idle();
    pc_d = 32'h3000; instr_d = 32'h0000_FFFF; cmp_op = 0; br = 2'd1; fwd_rs = 4; fwd_rt = 4;
    #1;
    checks++;
    if (cmp_out !== 1'b1 || npc !== 32'h3000) begin
      failures++; $display("FAIL br_taken: cmp=%b npc=%h required 1 3000", cmp_out, npc);
    end
    fwd_rt = 5; #1;
    checks++;
    if (cmp_out !== 1'b0 || npc !== 32'h3004) begin
      failures++; $display("FAIL br_not_taken: cmp=%b npc=%h required 0 3004", cmp_out, npc);
    end
    for (int k = 0; k < 60; k++) begin
      pc_d = $urandom; instr_d = $urandom; cmp_op = 3'($urandom); br = 2'($urandom);
      jr = 1'($urandom); epc = $urandom; fwd_rt = $urandom;
      case ($urandom_range(0, 3))
        0: fwd_rs = 0;
        1: fwd_rs = fwd_rt;
        2: fwd_rs = 32'($urandom_range(0, 2)) - 32'd1;
        default: fwd_rs = $urandom;
      endcase
      #1;
      checks++;
      if (cmp_out !== m_cmp(cmp_op, fwd_rs, fwd_rt) || npc !== m_npc()) begin
        failures++;
        $display("FAIL npc_rand op=%0d br=%0d: cmp=%b npc=%h required %b %h", cmp_op, br,
                 cmp_out, npc, m_cmp(cmp_op, fwd_rs, fwd_rt), m_npc());
      end
    end
  endtask

  task automatic test_de_control();
    idle();
    for (int k = 0; k < 4; k++) begin
      pc_d = $urandom; instr_d = $urandom; valid_d = 1; wr_en_d = 1'($urandom);
      a3_d = 5'($urandom); ext_op = 2'($urandom);
      stall_d = (k == 1 || k == 2);
      tick();
      checks++;
      if (pc_e !== e_pc || instr_e !== e_instr || rd1_e !== e_rd1 || rd2_e !== e_rd2 ||
          ext_e !== e_ext || valid_e !== e_valid || wr_en_e !== e_wr || a3_e !== e_a3) begin
        failures++;
        $display("FAIL de_stall%0d: pc_e=%h instr_e=%h rd1_e=%h ext_e=%h v=%b a3=%0d required %h %h %h %h %b %0d",
                 k, pc_e, instr_e, rd1_e, ext_e, valid_e, a3_e, e_pc, e_instr, e_rd1, e_ext, e_valid, e_a3);
      end
    end
    stall_d = 1; flush_e = 1; pc_d = $urandom; valid_d = 1;
    tick();
    checks++;
    if (pc_e !== 0 || instr_e !== 0 || rd1_e !== 0 || rd2_e !== 0 || ext_e !== 0 ||
        valid_e !== 0 || wr_en_e !== 0 || a3_e !== 0) begin
      failures++;
      $display("FAIL de_flush: pc_e=%h instr_e=%h valid_e=%b a3_e=%0d required all 0", pc_e, instr_e, valid_e, a3_e);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    instr_d = (32'd9 << 21) | (32'd9 << 16);
    valid_d = 1; wr_en_d = 1; a3_d = 5'd9;
    tick(); tick();
    valid_d = 0;
    we_w = 1; a3_w = 5'd9; #1;
    checks++;
    if (busy_rs !== 1'b1) begin
      failures++; $display("FAIL sb_two_pending: busy_rs=%b required 1", busy_rs);
    end
    tick();
    checks++;
    if (busy_rs !== m_busy(5'd9)) begin
      failures++; $display("FAIL sb_drain_cycle: busy_rs=%b required %b", busy_rs, m_busy(5'd9));
    end
    we_w = 0; #1;
    checks++;
    if (busy_rs !== 1'b1 || busy_rt !== 1'b1) begin
      failures++; $display("FAIL sb_one_left: busy=%b%b required 11", busy_rs, busy_rt);
    end
    we_w = 1; tick(); we_w = 0; #1;
    checks++;
    if (busy_rs !== 1'b0) begin
      failures++; $display("FAIL sb_cleared: busy_rs=%b required 0", busy_rs);
    end
    valid_d = 1; tick();
    we_w = 1; tick();
    valid_d = 0; we_w = 0; #1;
    checks++;
    if (busy_rs !== 1'b1) begin
      failures++; $display("FAIL sb_same_cycle: busy_rs=%b required 1", busy_rs);
    end
    we_w = 1; tick(); we_w = 0; #1;
    checks++;
    if (busy_rs !== 1'b0) begin
      failures++; $display("FAIL sb_same_cycle_drain: busy_rs=%b required 0", busy_rs);
    end
    for (int k = 0; k < 80; k++) begin
      valid_d = 1'($urandom); wr_en_d = 1'($urandom); a3_d = 5'($urandom_range(0, 3));
      we_w = 1'($urandom); a3_w = 5'($urandom_range(0, 3)); wd_w = $urandom;
      stall_d = ($urandom_range(0, 7) == 0); flush_e = ($urandom_range(0, 7) == 0);
      instr_d = $urandom;
      instr_d[25:21] = 5'($urandom_range(0, 3)); instr_d[20:16] = 5'($urandom_range(0, 3));
      #1;
      checks++;
      if (busy_rs !== m_busy(instr_d[25:21]) || busy_rt !== m_busy(instr_d[20:16])) begin
        failures++;
        $display("FAIL sb_rand rs=%0d rt=%0d: busy=%b%b required %b%b", instr_d[25:21], instr_d[20:16],
                 busy_rs, busy_rt, m_busy(instr_d[25:21]), m_busy(instr_d[20:16]));
      end
      tick();
    end
  endtask

  task automatic test_reset_override();
    idle();
    valid_d = 1; wr_en_d = 1; a3_d = 5'd12; pc_d = 32'h100;
    tick(); tick(); tick();
    reset = 1; stall_d = 1; flush_e = 0; we_w = 1; a3_w = 5'd12; wd_w = 32'hCAFE_F00D;
    tick();
    idle();
    instr_d = (32'd12 << 21) | (32'd5 << 16);
    #1;
    checks++;
    if (busy_rs !== 1'b0 || valid_e !== 1'b0 || npc !== 32'h4 || pc_e !== 0 || rd1 !== 0 || rd2 !== 0) begin
      failures++;
      $display("FAIL reset_override: busy_rs=%b valid_e=%b npc=%h pc_e=%h rd1=%h rd2=%h required 0 0 4 0 0 0",
               busy_rs, valid_e, npc, pc_e, rd1, rd2);
    end
  endtask

  task automatic test_back_to_back();
    idle();
    for (int k = 0; k < 150; k++) begin
      pc_d = $urandom; instr_d = $urandom;
      instr_d[25:21] = 5'($urandom_range(0, 7)); instr_d[20:16] = 5'($urandom_range(0, 7));
      valid_d = 1'($urandom); wr_en_d = 1'($urandom); a3_d = 5'($urandom_range(0, 7));
      ext_op = 2'($urandom); cmp_op = 3'($urandom); br = 2'($urandom); jr = 1'($urandom);
      fwd_rs = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom; fwd_rt = $urandom; epc = $urandom;
      we_w = 1'($urandom); a3_w = 5'($urandom_range(0, 7)); wd_w = $urandom;
      stall_d = ($urandom_range(0, 4) == 0); flush_e = ($urandom_range(0, 6) == 0);
      #1;
      checks++;
      if (rd1 !== m_read(instr_d[25:21]) || rd2 !== m_read(instr_d[20:16]) ||
          busy_rs !== m_busy(instr_d[25:21]) || busy_rt !== m_busy(instr_d[20:16]) ||
          cmp_out !== m_cmp(cmp_op, fwd_rs, fwd_rt) || npc !== m_npc()) begin
        failures++;
        $display("FAIL b2b_comb%0d: rd1=%h rd2=%h busy=%b%b cmp=%b npc=%h required %h %h %b%b %b %h", k,
                 rd1, rd2, busy_rs, busy_rt, cmp_out, npc, m_read(instr_d[25:21]), m_read(instr_d[20:16]),
                 m_busy(instr_d[25:21]), m_busy(instr_d[20:16]), m_cmp(cmp_op, fwd_rs, fwd_rt), m_npc());
      end
      tick();
      checks++;
      if (pc_e !== e_pc || instr_e !== e_instr || rd1_e !== e_rd1 || rd2_e !== e_rd2 ||
          ext_e !== e_ext || valid_e !== e_valid || wr_en_e !== e_wr || a3_e !== e_a3) begin
        failures++;
        $display("FAIL b2b_e%0d: pc_e=%h rd1_e=%h rd2_e=%h ext_e=%h v=%b w=%b a3=%0d required %h %h %h %h %b %b %0d",
                 k, pc_e, rd1_e, rd2_e, ext_e, valid_e, wr_en_e, a3_e, e_pc, e_rd1, e_rd2, e_ext,
                 e_valid, e_wr, e_a3);
      end
    end
  endtask

  initial begin
    idle();
    reset = 1;
    test_reset();
    test_regfile();
    test_same_cycle();
    test_ext();
    test_branch();
    test_de_control();
    test_scoreboard();
    test_reset_override();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
